risc16_bus_mem: RTL and testbench

Parametrised memory and memory-mapped I/O slave for the risc16 core. It provides byte-addressed, big-endian 16-bit word storage with per-byte write enables and a configurable number of wait states signalled through a `ready` handshake. It also contains an I/O window holding a LED output register pair and a free-running cycle counter. It sits directly on the core's `addr/din/dout/oe/we` bus. It is synthesizable and also serves as the memory model in core-level simulation.

---
 rtl/risc16_bus_mem_if.sv | 14 +
 rtl/risc16_bus_mem.sv | 132 +++++++++++++
 tb/tb_risc16_bus_mem.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc16_bus_mem_if.sv
// Core-side bus of the risc16 memory/I-O slave: address, write data, read data,
// request strobes, byte enables and the ready handshake.
interface risc16_bus_mem_if;
  logic [15:0] addr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        oe;
  logic        we;
  logic [1:0]  be;
  logic        ready;

  modport master (output addr, dout, oe, we, be, input din, ready);
  modport slave  (input addr, dout, oe, we, be, output din, ready);
endinterface

// File: rtl/risc16_bus_mem.sv
// Big-endian byte-addressed memory plus a 3-word I/O window (LED pair, cycle
// counter) with a programmable wait-state ready handshake.
module risc16_bus_mem #(
  parameter int          MEM_BYTES   = 65536,
  parameter logic [15:0] IO_BASE     = 16'h0200,
  parameter int          LED_WIDTH   = 24,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  risc16_bus_mem_if.slave      bus,
  output logic [LED_WIDTH-1:0] led
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [15:0] IO_LED_LO = IO_BASE;
  localparam logic [15:0] IO_LED_HI = IO_BASE + 16'd2;
  localparam logic [15:0] IO_CYC    = IO_BASE + 16'd4;
  localparam logic [3:0]  WS        = 4'(WAIT_STATES);
  localparam logic [31:0] LED_MASK  = 32'((64'd1 << LED_WIDTH) - 64'd1);
  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_WAIT   = 1'b1;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_w,
                                             input logic [15:0] new_w,
                                             input logic [1:0]  be);
    byte_merge[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
    byte_merge[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
  endfunction

  logic [7:0]    mem [MEM_BYTES];
  logic [0:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   led_q, led_d;
  logic [15:0]   cyc_q, cyc_d;
  logic [15:0]   wa, odd_addr, rd_data;
  logic [AW-1:0] idx_e, idx_o;
  logic          req, ready_c, wr_commit, mem_we;
  logic          sel_lo, sel_hi, sel_cyc, io_sel;

  assign req      = bus.oe | bus.we;
  assign wa       = {bus.addr[15:1], 1'b0};
  assign odd_addr = bus.addr | 16'h0001;
  assign idx_e    = wa[AW-1:0];
  assign idx_o    = odd_addr[AW-1:0];
  assign sel_lo   = (wa == IO_LED_LO);
  assign sel_hi   = (wa == IO_LED_HI);
  assign sel_cyc  = (wa == IO_CYC);
  assign io_sel   = sel_lo | sel_hi | sel_cyc;

  // Handshake: with no wait states ready simply follows the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_c = 1'b0;
    if (WAIT_STATES == 0) begin
      ready_c = req;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_d = ST_WAIT;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          if (!req) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == WS) begin
            ready_c = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  // A reset cycle never commits, even if it coincides with ready.
  assign wr_commit = ready_c & bus.we & ~rst;
  assign mem_we    = wr_commit & ~io_sel;

  always_comb begin
    led_d = led_q;
    cyc_d = cyc_q + 16'd1;
    if (wr_commit && sel_lo) led_d[15:0]  = byte_merge(led_q[15:0], bus.dout, bus.be);
    if (wr_commit && sel_hi) led_d[31:16] = byte_merge(led_q[31:16], bus.dout, bus.be);
    led_d = led_d & LED_MASK;
    if (wr_commit && sel_cyc && (bus.be != 2'b00))
      cyc_d = byte_merge(cyc_q, bus.dout, bus.be);
  end

  always_comb begin
    rd_data = 16'h0000;
    if (bus.oe) begin
      if (sel_lo)       rd_data = led_q[15:0];
      else if (sel_hi)  rd_data = led_q[31:16];
      else if (sel_cyc) rd_data = cyc_q;
      else              rd_data = {mem[idx_e], mem[idx_o]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      led_q   <= 32'd0;
      cyc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      cyc_q   <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (bus.be[1]) mem[idx_e] <= bus.dout[15:8];
      if (bus.be[0]) mem[idx_o] <= bus.dout[7:0];
    end
  end

  assign bus.din   = rd_data;
  assign bus.ready = ready_c;
  assign led       = led_q[LED_WIDTH-1:0];

endmodule

// File: tb/tb_risc16_bus_mem.sv
// Drives three differently configured instances from one shared bus and checks
// every cycle against a transaction-level model of storage, I/O and ready timing.
module tb_risc16_bus_mem;

  localparam int WSV  [3] = '{0, 3, 1};
  localparam int MEMV [3] = '{65536, 1024, 256};
  localparam int LEDV [3] = '{24, 32, 16};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] t_addr = 16'h0, t_dout = 16'h0;
  logic        t_oe = 1'b0, t_we = 1'b0, t_rst = 1'b0;
  logic [1:0]  t_be = 2'b00;
  bit          chk_en = 1'b0;

  risc16_bus_mem_if if_a ();
  risc16_bus_mem_if if_b ();
  risc16_bus_mem_if if_c ();
  logic [23:0] led_a;
  logic [31:0] led_b;
  logic [15:0] led_c;

  assign if_a.addr = t_addr; assign if_a.dout = t_dout; assign if_a.oe = t_oe;
  assign if_a.we   = t_we;   assign if_a.be   = t_be;
  assign if_b.addr = t_addr; assign if_b.dout = t_dout; assign if_b.oe = t_oe;
  assign if_b.we   = t_we;   assign if_b.be   = t_be;
  assign if_c.addr = t_addr; assign if_c.dout = t_dout; assign if_c.oe = t_oe;
  assign if_c.we   = t_we;   assign if_c.be   = t_be;

  risc16_bus_mem #(.MEM_BYTES(65536), .IO_BASE(16'h0200), .LED_WIDTH(24), .WAIT_STATES(0), .INIT_FILE(""))
    dut_a (.clk(clk), .rst(t_rst), .bus(if_a), .led(led_a));
  risc16_bus_mem #(.MEM_BYTES(1024), .IO_BASE(16'h0200), .LED_WIDTH(32), .WAIT_STATES(3), .INIT_FILE(""))
    dut_b (.clk(clk), .rst(t_rst), .bus(if_b), .led(led_b));
  risc16_bus_mem #(.MEM_BYTES(256), .IO_BASE(16'h0200), .LED_WIDTH(16), .WAIT_STATES(1), .INIT_FILE(""))
    dut_c (.clk(clk), .rst(t_rst), .bus(if_c), .led(led_c));

  logic [15:0] d_din [3];
  logic        d_rdy [3];
  logic [31:0] d_led [3];
  assign d_din[0] = if_a.din; assign d_rdy[0] = if_a.ready; assign d_led[0] = 32'(led_a);
  assign d_din[1] = if_b.din; assign d_rdy[1] = if_b.ready; assign d_led[1] = led_b;
  assign d_din[2] = if_c.din; assign d_rdy[2] = if_c.ready; assign d_led[2] = 32'(led_c);

  // Reference model state
  logic [7:0]  mm   [3][65536];
  bit          mk   [3][65536];
  logic [31:0] mled [3];
  logic [15:0] mcyc [3];
  int          held [3];

  // Literal expectations posted by the stimulus for the current cycle
  int          lit_n = 0;
  int          lit_k [4];
  int          lit_w [4];
  logic [31:0] lit_e [4];
  string       lit_nm [4];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] b);
    return {b[1] ? n[15:8] : o[15:8], b[0] ? n[7:0] : o[7:0]};
  endfunction

  function automatic logic [31:0] lmask(input int k);
    return (LEDV[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << LEDV[k]) - 32'd1);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] t=%0t got=%h expected=%h", nm, k, $time, got, exp);
    end
  endtask

  logic [15:0] c_wa, c_ed, c_hi;
  logic        c_er, c_ek, c_req, c_commit;
  int          c_ie, c_io;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      c_req = t_oe | t_we;
      c_wa  = t_addr & 16'hFFFE;
      c_er  = c_req && (held[k] == WSV[k]);
      c_ie  = int'(c_wa) % MEMV[k];
      c_io  = int'(t_addr | 16'h0001) % MEMV[k];
      c_ek  = 1'b1;
      if (!t_oe)                 c_ed = 16'h0000;
      else if (c_wa == 16'h0200) c_ed = mled[k][15:0];
      else if (c_wa == 16'h0202) c_ed = mled[k][31:16];
      else if (c_wa == 16'h0204) c_ed = mcyc[k];
      else begin
        c_ed = {mm[k][c_ie], mm[k][c_io]};
        c_ek = mk[k][c_ie] && mk[k][c_io];
      end

      if (chk_en) begin
        chk("ready", k, 32'(d_rdy[k]), 32'(c_er));
        chk("led", k, d_led[k], mled[k]);
        if (c_ek) chk("din", k, 32'(d_din[k]), 32'(c_ed));
        for (int i = 0; i < lit_n; i++) begin
          if (lit_k[i] == k) begin
            case (lit_w[i])
              0: begin
                chk(lit_nm[i], k, 32'(d_din[k]), lit_e[i]);
                chk({lit_nm[i], "_model"}, k, c_ek ? 32'(c_ed) : 32'h0001_0000, lit_e[i]);
              end
              1: begin
                chk(lit_nm[i], k, 32'(d_rdy[k]), lit_e[i]);
                chk({lit_nm[i], "_model"}, k, 32'(c_er), lit_e[i]);
              end
              default: begin
                chk(lit_nm[i], k, d_led[k], lit_e[i]);
                chk({lit_nm[i], "_model"}, k, mled[k], lit_e[i]);
              end
            endcase
          end
        end
      end

      c_commit = c_er && t_we && !t_rst;
      if (t_rst) begin
        mcyc[k] = 16'h0000;
        mled[k] = 32'h0;
      end else begin
        if (c_commit && c_wa == 16'h0204 && t_be != 2'b00) mcyc[k] = merge16(mcyc[k], t_dout, t_be);
        else                                               mcyc[k] = mcyc[k] + 16'd1;
        if (c_commit && c_wa == 16'h0200)
          mled[k] = {mled[k][31:16], merge16(mled[k][15:0], t_dout, t_be)} & lmask(k);
        if (c_commit && c_wa == 16'h0202) begin
          c_hi    = merge16(mled[k][31:16], t_dout, t_be);
          mled[k] = {c_hi, mled[k][15:0]} & lmask(k);
        end
        if (c_commit && c_wa != 16'h0200 && c_wa != 16'h0202 && c_wa != 16'h0204) begin
          if (t_be[1]) begin mm[k][c_ie] = t_dout[15:8]; mk[k][c_ie] = 1'b1; end
          if (t_be[0]) begin mm[k][c_io] = t_dout[7:0];  mk[k][c_io] = 1'b1; end
        end
      end
      if (t_rst || !c_req || c_er) held[k] = 0;
      else                         held[k] = held[k] + 1;
    end
  end

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic o, input logic w,
                      input logic [1:0] b, input logic r);
    @(posedge clk);
    #1;
    t_addr = a; t_dout = d; t_oe = o; t_we = w; t_be = b; t_rst = r;
    lit_n = 0;
  endtask

  task automatic expect_lit(input int k, input int what, input logic [31:0] e, input string nm);
    lit_k[lit_n] = k; lit_w[lit_n] = what; lit_e[lit_n] = e; lit_nm[lit_n] = nm;
    lit_n++;
  endtask

  task automatic idle();
    step(t_addr, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic acc(input logic [15:0] a, input logic [15:0] d, input logic o, input logic w,
                     input logic [1:0] b, input int len, input bit rst_last);
    for (int i = 0; i < len; i++) step(a, d, o, w, b, rst_last && (i == len - 1));
    idle();
  endtask

  int pool [11] = '{16'h0000, 16'h0010, 16'h0012, 16'h00FE, 16'h0100, 16'h0102,
                    16'h01FE, 16'h0200, 16'h0202, 16'h0204, 16'h0206};

  initial begin
    step(16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    step(16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk_en = 1'b1;
    expect_lit(0, 2, 32'h0, "reset_led");
    expect_lit(1, 1, 32'h0, "reset_ready");
    step(16'h0010, 16'h0, 1'b0, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'h0, "din_oe_low");

    // Word write then read through the odd address
    acc(16'h0010, 16'hA55A, 1'b0, 1'b1, 2'b11, 4, 1'b0);
    step(16'h0011, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'hA55A, "word_rd");
    expect_lit(2, 0, 32'hA55A, "word_rd");
    idle();

    acc(16'h0010, 16'h1234, 1'b0, 1'b1, 2'b01, 4, 1'b0);
    step(16'h0010, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'hA534, "byte_en");
    expect_lit(1, 0, 32'hA534, "byte_en");
    idle();

    acc(16'h0200, 16'hBEEF, 1'b0, 1'b1, 2'b11, 4, 1'b0);
    acc(16'h0202, 16'h00C3, 1'b0, 1'b1, 2'b11, 4, 1'b0);
    expect_lit(0, 2, 32'h00C3_BEEF, "led24");
    expect_lit(1, 2, 32'h00C3_BEEF, "led32");
    expect_lit(2, 2, 32'h0000_BEEF, "led16");
    step(16'h0200, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'hBEEF, "led_lo_rd");
    idle();
    step(16'h0202, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'h00C3, "led_hi_rd");
    expect_lit(2, 0, 32'h0000, "led_hi_unimpl");
    idle();

    // Wait states on instance 1: ready only in the 4th held cycle
    for (int i = 0; i < 4; i++) begin
      step(16'h0010, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
      expect_lit(1, 1, (i == 3) ? 32'h1 : 32'h0, "ws_ready");
    end
    idle();
    step(16'h0010, 16'hFFFF, 1'b0, 1'b1, 2'b11, 1'b0);
    step(16'h0010, 16'hFFFF, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step(16'h0010, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
      expect_lit(1, 1, (i == 3) ? 32'h1 : 32'h0, "ws_after_abort");
      if (i == 3) expect_lit(1, 0, 32'hA534, "abort_no_write");
      if (i == 0) expect_lit(0, 0, 32'hFFFF, "ws0_write");
    end
    idle();

    // Counter load then wrap
    step(16'h0204, 16'hFFFE, 1'b0, 1'b1, 2'b11, 1'b0);
    idle();
    step(16'h0204, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'hFFFF, "cnt_pre_wrap");
    step(16'h0204, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'h0000, "cnt_wrap");
    idle();
    step(16'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
    step(16'h0204, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(0, 0, 32'h0000, "cnt_after_rst");
    expect_lit(0, 2, 32'h0, "led_after_rst");
    idle();

    // Reset in the middle of a waiting write
    acc(16'h0012, 16'hDEAD, 1'b0, 1'b1, 2'b11, 2, 1'b1);

    // Address wrap on the 256-byte instance
    acc(16'h0102, 16'h1357, 1'b0, 1'b1, 2'b11, 4, 1'b0);
    step(16'h0002, 16'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    expect_lit(2, 0, 32'h1357, "addr_wrap");
    idle();

    for (int i = 0; i < 11; i++)
      if (pool[i] < 16'h0200 || pool[i] > 16'h0204)
        acc(16'(pool[i]), 16'($urandom), 1'b0, 1'b1, 2'b11, 4, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = 16'(pool[$urandom_range(0, 10)]) | 16'($urandom_range(0, 1));
      acc(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)), int'($urandom_range(1, 8)), ($urandom_range(0, 9) == 0));
    end

    idle();
    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
